downstream_rmw_arbiter: RTL and testbench

Sequences all read-modify-write traffic to the downstream cancelled-orders RAM (ramdownstream).
It shares one RAM port pair between NUM_REQ cancellation requesters using round-robin arbitration. Each granted request is serialized as read old total, add amount with saturation, write new total.
After reset, or on command, it sweeps the RAM to zero before accepting any traffic.

---
 rtl/downstream_pkg.sv | 19 +
 rtl/downstream_rmw_arbiter_if.sv | 42 ++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/downstream_rmw_arbiter.sv | 132 +++++++++++++
 tb/tb_downstream_rmw_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/downstream_pkg.sv
// Shared types and default sizing for the downstream cancelled-orders RMW arbiter.
// The saturation constant is the value written when an update overflows DATA_W bits.
package downstream_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DEPTH   = 32;

  localparam logic [DEF_DATA_W-1:0] SAT_VALUE = {DEF_DATA_W{1'b1}};

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/downstream_rmw_arbiter_if.sv
// Requester, clear-control, RAM-port and completion signals of the RMW arbiter.
// The arbiter takes the slave modport; requesters, RAM and observers sit on master.
interface downstream_rmw_arbiter_if
  import downstream_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_client_id;
  logic [NUM_REQ*DATA_W-1:0] req_amount;

  logic                      clear_start;
  logic                      clear_busy;

  logic [ADDR_W-1:0]         ram_rd_addr;
  logic [DATA_W-1:0]         ram_rd_data;
  logic                      ram_wr_en;
  logic [ADDR_W-1:0]         ram_wr_addr;
  logic [DATA_W-1:0]         ram_wr_data;

  logic                      done_valid;
  logic [ADDR_W-1:0]         done_client_id;
  logic [DATA_W-1:0]         done_total;
  logic                      done_sat;

  modport slave (
    input  req_valid, req_client_id, req_amount, clear_start, ram_rd_data,
    output req_ready, clear_busy, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
    output done_valid, done_client_id, done_total, done_sat
  );

  modport master (
    output req_valid, req_client_id, req_amount, clear_start, ram_rd_data,
    input  req_ready, clear_busy, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
    input  done_valid, done_client_id, done_total, done_sat
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// The pointer register lives in the parent so it advances only on accepted grants.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic [PTR_W:0] pos;
  logic           found;

  // NOTE: combinational logic uses blocking '=' so later statements see earlier results.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(i);
      if (pos >= (PTR_W+1)'(NUM_REQ)) pos = pos - (PTR_W+1)'(NUM_REQ);
      if (en && !found && req[pos[PTR_W-1:0]]) begin
        found                = 1'b1;
        gnt[pos[PTR_W-1:0]]  = 1'b1;
        gnt_idx              = pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/downstream_rmw_arbiter.sv
// Serialises saturating read-modify-write updates to the cancelled-orders RAM from
// NUM_REQ requesters, and zero-sweeps the RAM after reset or on clear_start.
module downstream_rmw_arbiter
  import downstream_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     HRESETn,
  downstream_rmw_arbiter_if.slave  bus
);

  localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]  id_q, id_d;
  logic [DATA_W-1:0]  amt_q, amt_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  sel_id;
  logic [DATA_W-1:0]  sel_amt;
  logic [DATA_W:0]    sum;
  logic               arb_en;

  // clear_start wins over requests, so the arbiter is blocked in that cycle.
  assign arb_en  = (state_q == IDLE) && !bus.clear_start;
  assign sel_id  = bus.req_client_id[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_amt = bus.req_amount[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sum     = {1'b0, bus.ram_rd_data} + {1'b0, amt_q};

  assign bus.ram_rd_addr = rd_addr_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      id_q      <= '0;
      amt_q     <= '0;
      rd_addr_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      amt_q     <= amt_d;
      rd_addr_q <= rd_addr_d;
      ptr_q     <= ptr_d;
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path infers a latch.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    id_d               = id_q;
    amt_d              = amt_q;
    rd_addr_d          = rd_addr_q;
    ptr_d              = ptr_q;
    bus.req_ready      = '0;
    bus.clear_busy     = 1'b0;
    bus.ram_wr_en      = 1'b0;
    bus.ram_wr_addr    = '0;
    bus.ram_wr_data    = '0;
    bus.done_valid     = 1'b0;
    bus.done_client_id = '0;
    bus.done_total     = '0;
    bus.done_sat       = 1'b0;

    unique case (state_q)
      CLEAR: begin
        // Reset parks the FSM in CLEAR; gating keeps the sweep outputs low while it is held.
        bus.clear_busy  = HRESETn;
        bus.ram_wr_en   = HRESETn;
        bus.ram_wr_addr = cnt_q;
        cnt_d           = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (bus.clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (|gnt) begin
          bus.req_ready = gnt;
          id_d          = sel_id;
          amt_d         = sel_amt;
          rd_addr_d     = sel_id;
          ptr_d         = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
          state_d       = READ;
        end
      end
      READ: begin
        state_d = WRITE;
      end
      WRITE: begin
        bus.ram_wr_en      = 1'b1;
        bus.ram_wr_addr    = id_q;
        bus.ram_wr_data    = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
        bus.done_valid     = 1'b1;
        bus.done_client_id = id_q;
        bus.done_total     = bus.ram_wr_data;
        bus.done_sat       = sum[DATA_W];
        state_d            = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_downstream_rmw_arbiter.sv
// Directed bench for downstream_rmw_arbiter: cycle table for the RMW traffic plus
// hand-written sequences for the sweep, clear priority and reset-abort cases.
module tb_downstream_rmw_arbiter;

  localparam int NR  = 2;
  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int DEP = 32;

  logic clk     = 1'b0;
  logic HRESETn = 1'b0;
  always #5 clk = ~clk;

  downstream_rmw_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

  downstream_rmw_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .DEPTH   (DEP)
  ) dut (
    .clk     (clk),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  // RAM model: synchronous read with one-cycle latency, bench preload port wins.
  logic [DW-1:0] mem [DEP];
  logic [DW-1:0] rd_data_q = '0;
  logic          pre_en    = 1'b0;
  logic [AW-1:0] pre_addr  = '0;
  logic [DW-1:0] pre_data  = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    rd_data_q <= mem[bus.ram_rd_addr];
  end
  assign bus.ram_rd_data = rd_data_q;

  // Watches for any committed or written update to client 4 while armed.
  logic mon_en = 1'b0;
  int   done4  = 0;
  int   bad4   = 0;
  always @(posedge clk) begin
    if (mon_en) begin
      if (bus.done_valid && bus.done_client_id == 5'd4) done4 <= done4 + 1;
      if (bus.ram_wr_en && bus.ram_wr_addr == 5'd4 && bus.ram_wr_data != '0) bad4 <= bad4 + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input int i0, input int a0, input int i1, input int a1);
    bus.req_valid     = v;
    bus.req_client_id = {AW'(i1), AW'(i0)};
    bus.req_amount    = {DW'(a1), DW'(a0)};
  endtask

  task automatic preload(input int addr, input int data);
    pre_en   = 1'b1;
    pre_addr = AW'(addr);
    pre_data = DW'(data);
    @(posedge clk); #1;
    pre_en   = 1'b0;
  endtask

  typedef struct {
    logic [1:0] v;
    int         i0, a0, i1, a1;
    logic [1:0] rdy;
    int         rd;
    logic       wen;
    int         wdata;
    logic       sat;
    logic       pre;
    int         pre_addr, pre_data;
  } row_t;

  row_t rows[$];

  // wr_addr and done_client_id are expected to equal rd when a write is expected, 0 otherwise.
  function automatic void add(input logic [1:0] v, input int i0, input int a0, input int i1,
                              input int a1, input logic [1:0] rdy, input int rd, input logic wen,
                              input int wdata, input logic sat);
    row_t r;
    r.v = v; r.i0 = i0; r.a0 = a0; r.i1 = i1; r.a1 = a1;
    r.rdy = rdy; r.rd = rd; r.wen = wen; r.wdata = wdata; r.sat = sat;
    r.pre = 1'b0; r.pre_addr = 0; r.pre_data = 0;
    rows.push_back(r);
  endfunction

  function automatic void add_pre(input int addr, input int data);
    rows[rows.size()-1].pre      = 1'b1;
    rows[rows.size()-1].pre_addr = addr;
    rows[rows.size()-1].pre_data = data;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rdy_bad;
    row_t r;

    // Both requesters streaming: grants alternate 0,1,... totals climb 1..4.
    for (int k = 0; k < 8; k++) begin
      int g, id, tot, prev;
      g    = k % 2;
      id   = (g == 0) ? 1 : 2;
      tot  = k / 2 + 1;
      prev = (k == 0) ? 0 : ((g == 0) ? 2 : 1);
      add(2'b11, 1, 1, 2, 1, 2'(1 << g), prev, 1'b0, 0, 1'b0);
      add(2'b11, 1, 1, 2, 1, 2'b00, id, 1'b0, 0, 1'b0);
      add(2'b11, 1, 1, 2, 1, 2'b00, id, 1'b1, tot, 1'b0);
    end
    add(2'b00, 0, 0, 0, 0, 2'b00, 2, 1'b0, 0, 1'b0);
    add_pre(8, 'hFFF0);
    // Requester 0 on client 3: 10 then 5, grants three cycles apart.
    add(2'b01, 3, 10, 0, 0, 2'b01, 2, 1'b0, 0, 1'b0);
    add(2'b01, 3,  5, 0, 0, 2'b00, 3, 1'b0, 0, 1'b0);
    add(2'b01, 3,  5, 0, 0, 2'b00, 3, 1'b1, 10, 1'b0);
    add(2'b01, 3,  5, 0, 0, 2'b01, 3, 1'b0, 0, 1'b0);
    add(2'b00, 0,  0, 0, 0, 2'b00, 3, 1'b0, 0, 1'b0);
    add(2'b00, 0,  0, 0, 0, 2'b00, 3, 1'b1, 15, 1'b0);
    add(2'b00, 0,  0, 0, 0, 2'b00, 3, 1'b0, 0, 1'b0);
    add_pre(7, 'hFFF0);
    // Saturation on client 7, then amount 0 keeps all-ones without flagging.
    add(2'b01, 7, 'h20, 0, 0, 2'b01, 3, 1'b0, 0, 1'b0);
    add(2'b01, 7, 0, 0, 0, 2'b00, 7, 1'b0, 0, 1'b0);
    add(2'b01, 7, 0, 0, 0, 2'b00, 7, 1'b1, 'hFFFF, 1'b1);
    add(2'b01, 7, 0, 0, 0, 2'b01, 7, 1'b0, 0, 1'b0);
    add(2'b00, 0, 0, 0, 0, 2'b00, 7, 1'b0, 0, 1'b0);
    add(2'b00, 0, 0, 0, 0, 2'b00, 7, 1'b1, 'hFFFF, 1'b0);
    // Sum landing exactly on all-ones is not a saturation.
    add(2'b01, 8, 'h0F, 0, 0, 2'b01, 7, 1'b0, 0, 1'b0);
    add(2'b00, 0, 0, 0, 0, 2'b00, 8, 1'b0, 0, 1'b0);
    add(2'b00, 0, 0, 0, 0, 2'b00, 8, 1'b1, 'hFFFF, 1'b0);
    add(2'b00, 0, 0, 0, 0, 2'b00, 8, 1'b0, 0, 1'b0);
    add_pre(5, 'h1234);

    drive(2'b00, 0, 0, 0, 0);
    bus.clear_start = 1'b0;

    // Reset held: fill a few RAM words with junk the sweep must erase.
    repeat (2) @(posedge clk);
    #1;
    preload(0, 'hDEAD);
    preload(4, 'hBEEF);
    preload(31, 'h5A5A);
    @(negedge clk);
    check("rst clear_busy", 32'(bus.clear_busy), 0);
    check("rst wr_en", 32'(bus.ram_wr_en), 0);
    check("rst ready", 32'(bus.req_ready), 0);
    check("rst done_valid", 32'(bus.done_valid), 0);
    check("rst rd_addr", 32'(bus.ram_rd_addr), 0);

    @(posedge clk); #1;
    HRESETn = 1'b1;
    drive(2'b01, 9, 1, 0, 0);
    for (int k = 0; k < DEP; k++) begin
      @(negedge clk);
      check($sformatf("sweep%0d busy", k), 32'(bus.clear_busy), 1);
      check($sformatf("sweep%0d wr_en", k), 32'(bus.ram_wr_en), 1);
      check($sformatf("sweep%0d wr_addr", k), 32'(bus.ram_wr_addr), 32'(k));
      check($sformatf("sweep%0d wr_data", k), 32'(bus.ram_wr_data), 0);
      check($sformatf("sweep%0d ready", k), 32'(bus.req_ready), 0);
      @(posedge clk); #1;
    end
    drive(2'b00, 0, 0, 0, 0);
    check("sweep mem0", 32'(mem[0]), 0);
    check("sweep mem4", 32'(mem[4]), 0);
    check("sweep mem31", 32'(mem[31]), 0);

    for (int i = 0; i < rows.size(); i++) begin
      r = rows[i];
      drive(r.v, r.i0, r.a0, r.i1, r.a1);
      pre_en   = r.pre;
      pre_addr = AW'(r.pre_addr);
      pre_data = DW'(r.pre_data);
      @(negedge clk);
      check($sformatf("r%0d ready", i), 32'(bus.req_ready), 32'(r.rdy));
      check($sformatf("r%0d rd_addr", i), 32'(bus.ram_rd_addr), 32'(r.rd));
      check($sformatf("r%0d wr_en", i), 32'(bus.ram_wr_en), 32'(r.wen));
      check($sformatf("r%0d wr_addr", i), 32'(bus.ram_wr_addr), r.wen ? 32'(r.rd) : 0);
      check($sformatf("r%0d wr_data", i), 32'(bus.ram_wr_data), 32'(r.wdata));
      check($sformatf("r%0d done_valid", i), 32'(bus.done_valid), 32'(r.wen));
      check($sformatf("r%0d done_id", i), 32'(bus.done_client_id), r.wen ? 32'(r.rd) : 0);
      check($sformatf("r%0d done_total", i), 32'(bus.done_total), 32'(r.wdata));
      check($sformatf("r%0d done_sat", i), 32'(bus.done_sat), 32'(r.sat));
      check($sformatf("r%0d busy", i), 32'(bus.clear_busy), 0);
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
    check("mem client1", 32'(mem[1]), 4);
    check("mem client2", 32'(mem[2]), 4);
    check("mem client3", 32'(mem[3]), 15);
    check("mem client7", 32'(mem[7]), 'hFFFF);

    // clear_start and a request in the same IDLE cycle: sweep first, then serve.
    drive(2'b01, 5, 3, 0, 0);
    bus.clear_start = 1'b1;
    @(negedge clk);
    check("clr_prio ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    bus.clear_start = 1'b0;
    n = 0;
    rdy_bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!bus.clear_busy) break;
      n++;
      if (bus.req_ready != '0) rdy_bad++;
      @(posedge clk); #1;
    end
    check("clr_prio sweep len", 32'(n), 32'(DEP));
    check("clr_prio ready in sweep", 32'(rdy_bad), 0);
    check("clr_prio late grant", 32'(bus.req_ready), 2'b01);
    @(posedge clk); #1;
    drive(2'b00, 0, 0, 0, 0);
    bus.clear_start = 1'b1;
    @(negedge clk);
    check("clr_prio rd_addr", 32'(bus.ram_rd_addr), 5);
    @(posedge clk); #1;
    bus.clear_start = 1'b0;
    @(negedge clk);
    check("clr_prio done", 32'(bus.done_valid), 1);
    check("clr_prio total", 32'(bus.done_total), 3);
    @(posedge clk); #1;
    @(negedge clk);
    check("clr_ignored busy", 32'(bus.clear_busy), 0);
    @(posedge clk); #1;

    // Reset while the client-4 update is in READ: no write, sweep restarts at 0.
    preload(4, 'h50);
    mon_en = 1'b1;
    drive(2'b01, 4, 9, 0, 0);
    @(negedge clk);
    check("abort grant", 32'(bus.req_ready), 2'b01);
    @(posedge clk); #1;
    drive(2'b00, 0, 0, 0, 0);
    HRESETn = 1'b0;
    @(negedge clk);
    check("abort wr_en", 32'(bus.ram_wr_en), 0);
    check("abort done", 32'(bus.done_valid), 0);
    check("abort busy", 32'(bus.clear_busy), 0);
    @(posedge clk); #1;
    HRESETn = 1'b1;
    @(negedge clk);
    check("abort sweep busy", 32'(bus.clear_busy), 1);
    check("abort sweep addr0", 32'(bus.ram_wr_addr), 0);
    n = 1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!bus.clear_busy) break;
      n++;
    end
    check("abort sweep len", 32'(n), 32'(DEP));
    check("abort mem4", 32'(mem[4]), 0);
    check("abort done4", 32'(done4), 0);
    check("abort write4", 32'(bad4), 0);
    mon_en = 1'b0;

    // Pointer is back at 0 after reset: requester 0 wins a tie.
    @(posedge clk); #1;
    drive(2'b11, 10, 1, 11, 2);
    @(negedge clk);
    check("post_rst ptr grant", 32'(bus.req_ready), 2'b01);
    @(posedge clk); #1;
    drive(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst done id", 32'(bus.done_client_id), 10);
    check("post_rst total", 32'(bus.done_total), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
